// File: rtl/nodf_module_if.sv
// Passive status tracker for one non-dataflow HLS kernel's ap_start/ap_ready/ap_done/ap_continue handshake.
// Exposes registered execution state, transaction counts, latencies, continue-stall cycles and a sticky error flag.
module nodf_module_if #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [LAT_W-1:0] cur_lat,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             proto_err,
  output logic             finished
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;
  logic [LAT_W-1:0] cur_lat_q,   cur_lat_d;
  logic [LAT_W-1:0] last_lat_q,  last_lat_d;
  logic [LAT_W-1:0] max_lat_q,   max_lat_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             finished_q,  finished_d;

  logic             rec_en_s;
  logic [LAT_W-1:0] rec_lat_s;
  logic [LAT_W-1:0] lat_inc_s;
  logic             viol_s;

  // Next-state, counter and latency-recording logic
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    done_cnt_d  = done_cnt_q;
    cur_lat_d   = cur_lat_q;
    last_lat_d  = last_lat_q;
    max_lat_d   = max_lat_q;
    stall_cnt_d = stall_cnt_q;
    proto_err_d = proto_err_q;
    finished_d  = finished_q;
    rec_en_s    = 1'b0;
    rec_lat_s   = {LAT_W{1'b0}};
    lat_inc_s   = (cur_lat_q == LAT_MAX) ? cur_lat_q : cur_lat_q + LAT_ONE;
    viol_s      = (ap_ready & ~ap_start)
                | ((state_q == ST_IDLE) & ap_done & ~ap_start)
                | ((state_q == ST_WAIT) & ap_done);

    if (state_q == ST_FIN) begin
      state_d = ST_FIN;
    end else if (finish) begin
      // Events on the finish cycle itself are deliberately dropped.
      state_d    = ST_FIN;
      finished_d = 1'b1;
    end else begin
      if (ap_start & ap_ready) begin
        start_cnt_d = (start_cnt_q == CNT_MAX) ? start_cnt_q : start_cnt_q + CNT_ONE;
      end else begin
        start_cnt_d = start_cnt_q;
      end
      if (viol_s) begin
        proto_err_d = 1'b1;
      end else begin
        proto_err_d = proto_err_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (!ap_start) begin
            state_d = ST_IDLE;
          end else if (ap_done & ap_continue) begin
            rec_en_s  = 1'b1;
            rec_lat_s = LAT_ONE;
          end else if (ap_done) begin
            state_d   = ST_WAIT;
            cur_lat_d = LAT_ONE;
          end else begin
            state_d   = ST_RUN;
            cur_lat_d = LAT_ONE;
          end
        end
        ST_RUN: begin
          if (ap_done & ap_continue) begin
            state_d   = ST_IDLE;
            rec_en_s  = 1'b1;
            rec_lat_s = lat_inc_s;
          end else if (ap_done) begin
            // Latency is frozen here; waiting for continue does not extend it.
            state_d   = ST_WAIT;
            cur_lat_d = lat_inc_s;
          end else begin
            cur_lat_d = lat_inc_s;
          end
        end
        ST_WAIT: begin
          if (ap_continue) begin
            state_d   = ST_IDLE;
            rec_en_s  = 1'b1;
            rec_lat_s = cur_lat_q;
          end else begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (rec_en_s) begin
        last_lat_d = rec_lat_s;
        max_lat_d  = (rec_lat_s > max_lat_q) ? rec_lat_s : max_lat_q;
        done_cnt_d = (done_cnt_q == CNT_MAX) ? done_cnt_q : done_cnt_q + CNT_ONE;
        cur_lat_d  = {LAT_W{1'b0}};
      end else begin
        last_lat_d = last_lat_q;
      end
    end
  end

  // State and statistics registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= {CNT_W{1'b0}};
      done_cnt_q  <= {CNT_W{1'b0}};
      cur_lat_q   <= {LAT_W{1'b0}};
      last_lat_q  <= {LAT_W{1'b0}};
      max_lat_q   <= {LAT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      proto_err_q <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      done_cnt_q  <= done_cnt_d;
      cur_lat_q   <= cur_lat_d;
      last_lat_q  <= last_lat_d;
      max_lat_q   <= max_lat_d;
      stall_cnt_q <= stall_cnt_d;
      proto_err_q <= proto_err_d;
      finished_q  <= finished_d;
    end
  end

  assign state     = state_q;
  assign start_cnt = start_cnt_q;
  assign done_cnt  = done_cnt_q;
  assign cur_lat   = cur_lat_q;
  assign last_lat  = last_lat_q;
  assign max_lat   = max_lat_q;
  assign stall_cnt = stall_cnt_q;
  assign proto_err = proto_err_q;
  assign finished  = finished_q;

endmodule

// File: tb/tb_nodf_module_if.sv
// Directed bench for nodf_module_if: hand-computed expected status snapshots are queued
// as stimulus is applied and compared against the DUT outputs one cycle later.
module tb_nodf_module_if;

  logic        clock = 1'b0;
  logic        reset;
  logic        ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]  state;
  logic [31:0] start_cnt, done_cnt, cur_lat, last_lat, max_lat, stall_cnt;
  logic        proto_err, finished;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] sc, dc, cl, ll, ml, sl;
    logic        pe, fi;
  } exp_t;

  exp_t sb[$];

  nodf_module_if #(.CNT_W(32), .LAT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .cur_lat(cur_lat), .last_lat(last_lat), .max_lat(max_lat),
    .stall_cnt(stall_cnt), .proto_err(proto_err), .finished(finished)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic d, input logic c, input logic f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
  endtask

  task automatic step(input logic s, input logic r, input logic d, input logic c, input logic f);
    drive(s, r, d, c, f);
    tick();
  endtask

  task automatic push_exp(input logic [1:0] st, input int sc, input int dc, input int cl,
                          input int ll, input int ml, input int sl, input logic pe, input logic fi);
    exp_t e;
    e.st = st; e.sc = sc; e.dc = dc; e.cl = cl; e.ll = ll; e.ml = ml; e.sl = sl; e.pe = pe; e.fi = fi;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".state"},     {30'd0, state},     {30'd0, e.st});
      chk({tag, ".start_cnt"}, start_cnt,          e.sc);
      chk({tag, ".done_cnt"},  done_cnt,           e.dc);
      chk({tag, ".cur_lat"},   cur_lat,            e.cl);
      chk({tag, ".last_lat"},  last_lat,           e.ll);
      chk({tag, ".max_lat"},   max_lat,            e.ml);
      chk({tag, ".stall_cnt"}, stall_cnt,          e.sl);
      chk({tag, ".proto_err"}, {31'd0, proto_err}, {31'd0, e.pe});
      chk({tag, ".finished"},  {31'd0, finished},  {31'd0, e.fi});
    end
  endtask

  // One complete transaction of latency len (len >= 2), start accepted on its first cycle.
  task automatic txn(input int len);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < len - 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    reset = 1'b0;

    push_exp(2'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_idle");

    // Latency-5 transaction, ap_start held for all five cycles
    push_exp(2'd1, 1, 0, 1, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("run_first");
    push_exp(2'd1, 1, 0, 4, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("run_mid");
    push_exp(2'd0, 1, 1, 0, 5, 5, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("lat5_done");

    // Back-to-back transactions of latency 3, 7, 4
    push_exp(2'd0, 2, 2, 0, 3, 5, 0, 1'b0, 1'b0);
    txn(3);
    check("lat3");
    push_exp(2'd0, 3, 3, 0, 7, 7, 0, 1'b0, 1'b0);
    txn(7);
    check("lat7");
    push_exp(2'd0, 4, 4, 0, 4, 7, 0, 1'b0, 1'b0);
    txn(4);
    check("lat4");

    // Start and retire in the same IDLE cycle: latency 1
    push_exp(2'd0, 5, 5, 0, 1, 7, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("lat1");

    // Continue stall: done at latency 3, then four cycles of ap_continue low
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(2'd2, 6, 5, 3, 1, 7, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wait_enter");
    push_exp(2'd2, 6, 5, 3, 1, 7, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wait_stall");
    push_exp(2'd0, 6, 6, 0, 3, 7, 4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wait_release");

    // ap_done in IDLE without ap_start: sticky protocol error
    push_exp(2'd0, 6, 6, 0, 3, 7, 4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("perr_set");
    push_exp(2'd0, 6, 6, 0, 3, 7, 4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("perr_sticky");

    // finish mid-RUN; handshake on the finish cycle and afterwards is ignored
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(2'd3, 7, 6, 2, 3, 7, 4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("finish_enter");
    push_exp(2'd3, 7, 6, 2, 3, 7, 4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("finish_frozen");

    // Reset overrides finish and events in the same cycle
    reset = 1'b1;
    push_exp(2'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_override");
    reset = 1'b0;
    push_exp(2'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_after");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
